alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of the requester handshakes, the shared-ALU operand
//                and result bus, and the status outputs of alu_arbiter.
//                  slave  : the arbiter. It samples requests, operands and
//                           alu_result, and drives the ALU operands,
//                           done/result, busy and op_count.
//                  master : the environment, meaning both requesters and the
//                           shared ALU.
//  Ports       : (interface signals)
//                  req0/req1, a0/b0/a1/b1, op0/op1  requester side (in)
//                  alu_a, alu_b, alu_op             to shared ALU  (out)
//                  alu_result                       from shared ALU (in)
//                  done0/done1, result              completion     (out)
//                  busy, op_count                   status         (out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             op0;
    logic             op1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [15:0]      op_count;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1, alu_result,
        output alu_a, alu_b, alu_op, done0, done1, result, busy, op_count
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1, alu_result,
        input  alu_a, alu_b, alu_op, done0, done1, result, busy, op_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester arbiter in front of one shared combinational
//                ALU. The FSM walks IDLE -> EXEC -> RESP and grants requests
//                round-robin when both requesters ask at the same time.
//                The result is captured on the edge that leaves EXEC, and a
//                single-cycle done pulse goes to the owning requester in
//                RESP.
//  Ports       : clk    - sole clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - alu_arbiter_if.slave (requests, ALU bus, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  wire          clk,
    input  wire          rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic             grant_q,    grant_d;    // owner of the ALU (0/1)
    logic             rr_q,       rr_d;       // preferred requester on a tie
    logic [WIDTH-1:0] result_q,   result_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             w_any_req;
    logic             w_pick;

    assign w_any_req = bus.req0 | bus.req1;
    // A lone request picks itself (req1 alone gives 1, req0 alone gives 0).
    // On a tie the round-robin pointer decides.
    assign w_pick = (bus.req0 && bus.req1) ? rr_q : bus.req1;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        result_d   = result_q;
        op_count_d = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    grant_d = w_pick;
                    // After any grant, the other requester wins the next tie.
                    rr_d    = ~w_pick;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = bus.alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                op_count_d = op_count_q + 16'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. These are decoded from registered state, so an asynchronous
    // reset drives them to their idle values at once.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = 1'b0;
        if (state_q == ST_EXEC) begin
            if (grant_q) begin
                bus.alu_a  = bus.a1;
                bus.alu_b  = bus.b1;
                bus.alu_op = bus.op1;
            end else begin
                bus.alu_a  = bus.a0;
                bus.alu_b  = bus.b0;
                bus.alu_op = bus.op0;
            end
        end
    end

    assign bus.done0    = (state_q == ST_RESP) && !grant_q;
    assign bus.done1    = (state_q == ST_RESP) &&  grant_q;
    assign bus.result   = result_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.op_count = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter. The shared ALU
//                is modelled as a + b. Inputs are driven and outputs are
//                sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Shared ALU: modular addition
    assign bus.alu_result = bus.alu_a + bus.alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Check one EXEC/RESP pair of cycles for a known owner and sum
    task automatic check_op(input string tag, input logic who,
                            input logic [7:0] ea, input logic [7:0] eb,
                            input logic eop, input logic [7:0] eres);
        step(); // EXEC
        check_val({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
        check_val({tag, "_alu_a"},     32'(bus.alu_a), 32'(ea));
        check_val({tag, "_alu_b"},     32'(bus.alu_b), 32'(eb));
        check_val({tag, "_alu_op"},    32'(bus.alu_op), 32'(eop));
        check_val({tag, "_exec_done"}, 32'({bus.done1, bus.done0}), 32'd0);
        step(); // RESP
        check_val({tag, "_done0"},  32'(bus.done0), 32'(!who));
        check_val({tag, "_done1"},  32'(bus.done1), 32'(who));
        check_val({tag, "_result"}, 32'(bus.result), 32'(eres));
        check_val({tag, "_resp_alu_a"}, 32'(bus.alu_a), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.op0 = 1'b0; bus.op1 = 1'b0;

        // Reset state
        #2;
        check_val("rst_busy",   32'(bus.busy), 32'd0);
        check_val("rst_done",   32'({bus.done1, bus.done0}), 32'd0);
        check_val("rst_result", 32'(bus.result), 32'd0);
        check_val("rst_count",  32'(bus.op_count), 32'd0);
        check_val("rst_alu",    32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_val("idle_busy", 32'(bus.busy), 32'd0);

        // Single request from requester 0. req0 drops during EXEC, and the
        // operation must still complete.
        bus.req0 = 1'b1; bus.a0 = 8'h12; bus.b0 = 8'h34; bus.op0 = 1'b1;
        step(); // EXEC
        check_val("single_alu_a", 32'(bus.alu_a), 32'h12);
        check_val("single_alu_b", 32'(bus.alu_b), 32'h34);
        check_val("single_alu_op", 32'(bus.alu_op), 32'd1);
        check_val("single_busy", 32'(bus.busy), 32'd1);
        bus.req0 = 1'b0;
        step(); // RESP
        check_val("single_done0", 32'(bus.done0), 32'd1);
        check_val("single_done1", 32'(bus.done1), 32'd0);
        check_val("single_result", 32'(bus.result), 32'h46);
        step(); // IDLE
        check_val("single_done_off", 32'(bus.done0), 32'd0);
        check_val("single_count", 32'(bus.op_count), 32'd1);
        check_val("single_hold", 32'(bus.result), 32'h46);
        check_val("single_idle_busy", 32'(bus.busy), 32'd0);

        // Requester 1 with an addition that wraps
        bus.req1 = 1'b1; bus.a1 = 8'hF0; bus.b1 = 8'h20; bus.op1 = 1'b0;
        step(); // EXEC
        bus.req1 = 1'b0;
        check_val("wrap_alu_a", 32'(bus.alu_a), 32'hF0);
        check_val("wrap_alu_op", 32'(bus.alu_op), 32'd0);
        step(); // RESP
        check_val("wrap_done1", 32'(bus.done1), 32'd1);
        check_val("wrap_done0", 32'(bus.done0), 32'd0);
        check_val("wrap_result", 32'(bus.result), 32'h10);
        step();
        check_val("wrap_count", 32'(bus.op_count), 32'd2);

        // Contention from reset: the order must be 0,1,0,1
        do_reset();
        bus.a0 = 8'h01; bus.b0 = 8'h02; bus.op0 = 1'b1;
        bus.a1 = 8'h10; bus.b1 = 8'h20; bus.op1 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 0)
                check_op("rr0", 1'b0, 8'h01, 8'h02, 1'b1, 8'h03);
            else
                check_op("rr1", 1'b1, 8'h10, 8'h20, 1'b0, 8'h30);
            step(); // IDLE
            check_val("rr_idle_busy", 32'(bus.busy), 32'd0);
            if (k == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
        end
        step();
        check_val("rr_count", 32'(bus.op_count), 32'd4);

        // req0 held high for three operations back to back
        do_reset();
        bus.a0 = 8'h07; bus.b0 = 8'h08; bus.op0 = 1'b0;
        bus.req0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_op("b2b", 1'b0, 8'h07, 8'h08, 1'b0, 8'h0F);
            step(); // IDLE, busy low for one cycle
            check_val("b2b_idle_busy", 32'(bus.busy), 32'd0);
            if (k == 2) bus.req0 = 1'b0;
        end
        check_val("b2b_count", 32'(bus.op_count), 32'd3);

        // Reset during EXEC discards the operation
        bus.a0 = 8'h55; bus.b0 = 8'h11; bus.op0 = 1'b1;
        bus.req0 = 1'b1;
        step(); // EXEC
        check_val("mid_exec_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_busy", 32'(bus.busy), 32'd0);
        check_val("mid_result", 32'(bus.result), 32'd0);
        check_val("mid_count", 32'(bus.op_count), 32'd0);
        check_val("mid_alu", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
        step();
        check_val("mid_no_done", 32'({bus.done1, bus.done0}), 32'd0);
        rst_n = 1'b1;
        check_op("post_rst", 1'b0, 8'h55, 8'h11, 1'b1, 8'h66);
        bus.req0 = 1'b0;
        step();
        check_val("post_rst_count", 32'(bus.op_count), 32'd1);

        // op_count wrap: preload 0xFFFF, then run one operation
        force u_dut.op_count_q = 16'hFFFF;
        step();
        release u_dut.op_count_q;
        check_val("preload_count", 32'(bus.op_count), 32'hFFFF);
        bus.a1 = 8'hFF; bus.b1 = 8'h01; bus.op1 = 1'b1;
        bus.req1 = 1'b1;
        check_op("cnt_wrap", 1'b1, 8'hFF, 8'h01, 1'b1, 8'h00);
        bus.req1 = 1'b0;
        step();
        check_val("count_wrapped", 32'(bus.op_count), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
